// File: rtl/argmax_reader.sv
// Scans the engine's indexed score port after each done rise and reports the
// index and value of the signed maximum as a one-cycle valid pulse.
module argmax_reader #(
    parameter int DATA_WIDTH  = 2,
    parameter int NUM_CLASSES = 10,
    parameter int READ_LAT    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         done,
    output logic [3:0]                   out_idx,
    input  logic signed [DATA_WIDTH-1:0] out,
    output logic                         busy,
    output logic                         class_valid,
    output logic [3:0]                   class_out,
    output logic signed [DATA_WIDTH-1:0] max_score
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t                         r_state;
    logic                           r_done_q;
    logic [3:0]                     r_smp_cnt;
    logic                           r_wait;
    logic signed [DATA_WIDTH-1:0]   r_best;
    logic [3:0]                     r_best_idx;

    logic                           w_start;
    logic                           w_take;
    logic signed [DATA_WIDTH-1:0]   w_nxt_best;
    logic [3:0]                     w_nxt_idx;

    assign w_start    = done & ~r_done_q;
    // Strict compare keeps the lowest index on ties.
    assign w_take     = (r_smp_cnt == 4'd0) || (out > r_best);
    assign w_nxt_best = w_take ? out : r_best;
    assign w_nxt_idx  = w_take ? r_smp_cnt : r_best_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_done_q    <= 1'b0;
            r_smp_cnt   <= 4'd0;
            r_wait      <= 1'b0;
            r_best      <= '0;
            r_best_idx  <= 4'd0;
            out_idx     <= 4'd0;
            busy        <= 1'b0;
            class_valid <= 1'b0;
            class_out   <= 4'd0;
            max_score   <= '0;
        end else begin
            r_done_q    <= done;
            class_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    out_idx <= 4'd0;
                    if (w_start) begin
                        r_state   <= SCAN;
                        busy      <= 1'b1;
                        r_smp_cnt <= 4'd0;
                        r_wait    <= 1'(READ_LAT);
                    end
                end
                SCAN: begin
                    if (out_idx != LAST_IDX) begin
                        out_idx <= out_idx + 4'd1;
                    end
                    // With a registered source, the first cycle carries no valid data.
                    if (r_wait) begin
                        r_wait <= 1'b0;
                    end else begin
                        r_best     <= w_nxt_best;
                        r_best_idx <= w_nxt_idx;
                        r_smp_cnt  <= r_smp_cnt + 4'd1;
                        if (r_smp_cnt == LAST_IDX) begin
                            r_state     <= REPORT;
                            busy        <= 1'b0;
                            class_valid <= 1'b1;
                            class_out   <= w_nxt_idx;
                            max_score   <= w_nxt_best;
                        end
                    end
                end
                REPORT: begin
                    r_state <= IDLE;
                    out_idx <= 4'd0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_reader.sv
// Bench for argmax_reader: one instance with a combinational score source and
// one with a one-cycle registered source, both checked through result queues.
module tb_argmax_reader;

    localparam int DW = 2;
    localparam int NC = 10;

    typedef struct {
        int cls;
        int mx;
        int edge_n;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done = 1'b0;

    logic        [3:0]    out_idx0, out_idx1, class_out0, class_out1;
    logic signed [DW-1:0] out0, out1, max_score0, max_score1;
    logic                 busy0, busy1, class_valid0, class_valid1;

    logic signed [DW-1:0] sc [NC];

    exp_t q0[$];
    exp_t q1[$];

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign out0 = (out_idx0 < NC) ? sc[out_idx0] : '0;
    always @(posedge clk) out1 <= (out_idx1 < NC) ? sc[out_idx1] : '0;

    argmax_reader #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .READ_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .done(done), .out_idx(out_idx0), .out(out0),
        .busy(busy0), .class_valid(class_valid0), .class_out(class_out0),
        .max_score(max_score0)
    );

    argmax_reader #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .READ_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .done(done), .out_idx(out_idx1), .out(out1),
        .busy(busy1), .class_valid(class_valid1), .class_out(class_out1),
        .max_score(max_score1)
    );

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: each valid pulse pops one expectation; the latency check uses
    // the index of the rising edge that first samples the pulse.
    always @(negedge clk) begin
        exp_t e;
        if (class_valid0) begin
            if (q0.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_valid0: got pulse, expected none (cycle %0d)", cyc);
            end else begin
                e = q0.pop_front();
                chk("class0", int'(class_out0), e.cls);
                chk("max0", int'(max_score0), e.mx);
                chk("lat0", cyc + 1, e.edge_n);
            end
        end
        if (class_valid1) begin
            if (q1.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_valid1: got pulse, expected none (cycle %0d)", cyc);
            end else begin
                e = q1.pop_front();
                chk("class1", int'(class_out1), e.cls);
                chk("max1", int'(max_score1), e.mx);
                chk("lat1", cyc + 1, e.edge_n);
            end
        end
    end

    task automatic load(input int v[NC]);
        for (int i = 0; i < NC; i++) sc[i] = DW'(v[i]);
    endtask

    // Reference argmax: strict greater-than, so the lowest index wins ties.
    task automatic push_exp(input int e_edge);
        exp_t e;
        int bi = 0;
        int bv = int'(sc[0]);
        for (int i = 1; i < NC; i++) begin
            if (int'(sc[i]) > bv) begin
                bv = int'(sc[i]);
                bi = i;
            end
        end
        e.cls = bi;
        e.mx = bv;
        e.edge_n = e_edge + NC + 1;
        q0.push_back(e);
        e.edge_n = e_edge + NC + 2;
        q1.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s_timeout: got %0d/%0d pending results, expected 0", name, q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_scan(input string name);
        @(negedge clk);
        push_exp(cyc + 1);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        wait_drain(name);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy0"}, int'(busy0), 0);
        chk({tag, "_idx0"}, int'(out_idx0), 0);
        chk({tag, "_cls0"}, int'(class_out0), 0);
        chk({tag, "_max0"}, int'(max_score0), 0);
        chk({tag, "_valid0"}, int'(class_valid0), 0);
        chk({tag, "_busy1"}, int'(busy1), 0);
        chk({tag, "_idx1"}, int'(out_idx1), 0);
        chk({tag, "_cls1"}, int'(class_out1), 0);
    endtask

    initial begin
        int t1[NC] = '{0, 1, -1, 0, 1, 0, 0, -2, 0, 0};
        int t2[NC] = '{-2, -2, -2, -2, -2, -2, -2, -2, -2, -1};
        int t3[NC] = '{1, 0, 0, -2, 1, -1, 1, 0, 0, 1};
        int teq[NC] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        int tlo[NC] = '{-2, 0, -2, -1, 0, -2, 0, -1, 0, 1};

        load(t1);
        repeat (3) @(negedge clk);
        chk_reset_vals("rst_init");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_scan("basic");
        load(t2);
        run_scan("all_neg");
        load(t3);
        run_scan("max_idx0");
        load(teq);
        run_scan("all_equal");

        // done already high when reset releases, then held high
        load(tlo);
        @(negedge clk);
        rst = 1'b1;
        done = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_exp(cyc + 1);
        repeat (40) @(negedge clk);
        done = 1'b0;
        wait_drain("level_done");
        run_scan("second_rise");

        // reset during SCAN cycle 5
        load(t1);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (5) @(negedge clk);
        chk("midscan_busy0", int'(busy0), 1);
        chk("midscan_idx0", int'(out_idx0), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("rst_mid");
        repeat (25) @(negedge clk);

        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < NC; i++) sc[i] = DW'($urandom_range(0, 3));
            run_scan("random");
        end

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
